// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel raster feeder.
package pixel_pkg;

    localparam int unsigned COORD_W        = 11;
    localparam int unsigned PIX_W          = 8;
    localparam int unsigned MAX_WIDTH_DEF  = 1080;
    localparam int unsigned MAX_HEIGHT_DEF = 1080;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } feeder_state_e;

endpackage

// File: rtl/rgb_to_gray.sv
// Combinational luma approximation (R + 2G + B) / 4.
// Only built when PIXEL_RASTER_GRAYSCALE_EN is defined.
`ifdef PIXEL_RASTER_GRAYSCALE_EN
module rgb_to_gray
    import pixel_pkg::*;
(
    input  logic [PIX_W-1:0] r_i,
    input  logic [PIX_W-1:0] g_i,
    input  logic [PIX_W-1:0] b_i,
    output logic [PIX_W-1:0] gray_o
);

    logic [PIX_W+1:0] sum;

    always_comb begin
        sum    = {2'b00, r_i} + {1'b0, g_i, 1'b0} + {2'b00, b_i};
        gray_o = sum[PIX_W+1:2];
    end

endmodule
`endif

// File: rtl/pixel_raster_feeder.sv
// Accepts a stream of RGB pixels and tags each with raster row/col, one cycle later.
// Define PIXEL_RASTER_GRAYSCALE_EN to present a grayscale value on all three components.
module pixel_raster_feeder
    import pixel_pkg::*;
#(
    parameter int unsigned MAX_WIDTH  = MAX_WIDTH_DEF,
    parameter int unsigned MAX_HEIGHT = MAX_HEIGHT_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [31:0]        width,
    input  logic [31:0]        height,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_R,
    input  logic [PIX_W-1:0]   in_G,
    input  logic [PIX_W-1:0]   in_B,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic [PIX_W-1:0]   DATA_WRITE_R,
    output logic [PIX_W-1:0]   DATA_WRITE_G,
    output logic [PIX_W-1:0]   DATA_WRITE_B,
    output logic               out_valid,
    output logic               busy,
    output logic               frame_done
);

    feeder_state_e      state_q, state_d;
    logic [COORD_W-1:0] width_q, height_q;
    logic [COORD_W-1:0] cnt_row_q, cnt_col_q;
    logic [COORD_W-1:0] row_q, col_q;
    logic [PIX_W-1:0]   r_q, g_q, b_q;
    logic               out_valid_q;
    logic               dims_ok, launch, xfer, col_last, last_pix;
    logic [PIX_W-1:0]   pix_r, pix_g, pix_b;

`ifdef PIXEL_RASTER_GRAYSCALE_EN
    logic [PIX_W-1:0] gray;

    rgb_to_gray u_rgb_to_gray (
        .r_i    (in_R),
        .g_i    (in_G),
        .b_i    (in_B),
        .gray_o (gray)
    );

    assign pix_r = gray;
    assign pix_g = gray;
    assign pix_b = gray;
`else
    assign pix_r = in_R;
    assign pix_g = in_G;
    assign pix_b = in_B;
`endif

    always_comb begin
        dims_ok  = (width != 32'd0) && (width <= MAX_WIDTH) &&
                   (height != 32'd0) && (height <= MAX_HEIGHT);
        launch   = (state_q == StIdle) && start && dims_ok;
        xfer     = (state_q == StRun) && in_valid;
        col_last = (cnt_col_q == width_q - 11'd1);
        last_pix = col_last && (cnt_row_q == height_q - 11'd1);

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (launch) state_d = StRun;
            StRun:   if (xfer && last_pix) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            width_q     <= '0;
            height_q    <= '0;
            cnt_row_q   <= '0;
            cnt_col_q   <= '0;
            row_q       <= '0;
            col_q       <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= xfer;
            if (launch) begin
                // Range already checked, so the low bits hold the full dimension.
                width_q   <= width[COORD_W-1:0];
                height_q  <= height[COORD_W-1:0];
                cnt_row_q <= '0;
                cnt_col_q <= '0;
            end
            if (xfer) begin
                row_q <= cnt_row_q;
                col_q <= cnt_col_q;
                r_q   <= pix_r;
                g_q   <= pix_g;
                b_q   <= pix_b;
                if (col_last) begin
                    cnt_col_q <= '0;
                    cnt_row_q <= cnt_row_q + 11'd1;
                end else begin
                    cnt_col_q <= cnt_col_q + 11'd1;
                end
            end
        end
    end

    assign in_ready     = (state_q == StRun);
    assign busy         = (state_q != StIdle);
    assign frame_done   = (state_q == StDone);
    assign out_valid    = out_valid_q;
    assign row          = row_q;
    assign col          = col_q;
    assign DATA_WRITE_R = r_q;
    assign DATA_WRITE_G = g_q;
    assign DATA_WRITE_B = b_q;

endmodule

// File: tb/tb_pixel_raster_feeder.sv
// Directed bench for pixel_raster_feeder; follows PIXEL_RASTER_GRAYSCALE_EN for expected pixels.
module tb_pixel_raster_feeder;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] width, height;
    logic        start, in_valid, in_ready;
    logic [7:0]  in_R, in_G, in_B;
    logic [10:0] row, col;
    logic [7:0]  DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B;
    logic        out_valid, busy, frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    pixel_raster_feeder dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .width        (width),
        .height       (height),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_R         (in_R),
        .in_G         (in_G),
        .in_B         (in_B),
        .row          (row),
        .col          (col),
        .DATA_WRITE_R (DATA_WRITE_R),
        .DATA_WRITE_G (DATA_WRITE_G),
        .DATA_WRITE_B (DATA_WRITE_B),
        .out_valid    (out_valid),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
`ifdef PIXEL_RASTER_GRAYSCALE_EN
        logic [9:0] s;
        s = {2'b00, r} + {2'b00, g} + {2'b00, g} + {2'b00, b};
        return {s[9:2], s[9:2], s[9:2]};
`else
        return {r, g, b};
`endif
    endfunction

    function automatic logic [31:0] pix_out();
        return {8'h00, DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B};
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_row"}, 32'(row), 32'd0);
        chk({tag, "_col"}, 32'(col), 32'd0);
        chk({tag, "_pix"}, pix_out(), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
    endtask

    logic [4:0] vmask;
    int         idx;

    initial begin
        RESET = 1'b1; width = '0; height = '0; start = 1'b0; in_valid = 1'b0;
        in_R = '0; in_G = '0; in_B = '0;
        tick(); tick();
        RESET = 1'b0;
        tick();
        chk_idle_zero("reset");

        // 4x2 frame, in_valid held high
        width = 4; height = 2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("f1_start_ready", 32'(in_ready), 32'd1);
        chk("f1_start_busy", 32'(busy), 32'd1);
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_R = 8'(k); in_G = 8'(k + 1); in_B = 8'(k + 2);
            tick();
            chk("f1_valid", 32'(out_valid), 32'd1);
            chk("f1_row", 32'(row), 32'(k / 4));
            chk("f1_col", 32'(col), 32'(k % 4));
            chk("f1_pix", pix_out(), 32'(exp_pix(8'(k), 8'(k + 1), 8'(k + 2))));
            chk("f1_done", 32'(frame_done), 32'(k == 7));
            chk("f1_ready", 32'(in_ready), 32'(k != 7));
        end
        in_valid = 1'b0;
        tick();
        chk("f1_after_busy", 32'(busy), 32'd0);
        chk("f1_after_valid", 32'(out_valid), 32'd0);
        chk("f1_after_done", 32'(frame_done), 32'd0);
        chk("f1_after_row", 32'(row), 32'd1);
        chk("f1_after_col", 32'(col), 32'd3);

        // 3x1 frame with upstream gaps
        width = 3; height = 1; start = 1'b1;
        tick();
        start = 1'b0;
        vmask = 5'b10101;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = vmask[i];
            in_R = 8'(8'h10 + i); in_G = 8'(8'h20 + i); in_B = 8'(8'h30 + i);
            tick();
            if (vmask[i]) begin
                chk("f2_valid", 32'(out_valid), 32'd1);
                chk("f2_col", 32'(col), 32'(idx));
                chk("f2_pix", pix_out(),
                    32'(exp_pix(8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i))));
                idx++;
            end else begin
                chk("f2_gap_valid", 32'(out_valid), 32'd0);
                chk("f2_gap_col", 32'(col), 32'(idx - 1));
                chk("f2_gap_pix", pix_out(),
                    32'(exp_pix(8'(8'h10 + i - 1), 8'(8'h20 + i - 1), 8'(8'h30 + i - 1))));
            end
            chk("f2_row", 32'(row), 32'd0);
            chk("f2_done", 32'(frame_done), 32'(i == 4));
        end
        in_valid = 1'b0;
        tick();
        chk("f2_after_busy", 32'(busy), 32'd0);

        // Out-of-range dimensions are ignored
        width = 0; height = 2; start = 1'b1; in_valid = 1'b1;
        tick();
        chk("bad_w0_ready", 32'(in_ready), 32'd0);
        chk("bad_w0_busy", 32'(busy), 32'd0);
        width = 1081; height = 5;
        tick();
        chk("bad_w1081_ready", 32'(in_ready), 32'd0);
        chk("bad_w1081_valid", 32'(out_valid), 32'd0);
        width = 5; height = 1081;
        tick();
        chk("bad_h1081_ready", 32'(in_ready), 32'd0);
        start = 1'b0;
        tick();
        chk("bad_valid", 32'(out_valid), 32'd0);
        chk("bad_busy", 32'(busy), 32'd0);

        // 1080x1 is the largest width accepted
        width = 1080; height = 1; start = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0;
        chk("max_w_ready", 32'(in_ready), 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;

        // Reset after 5 transfers of a 4x4 frame, reset beats start and transfer
        width = 4; height = 4; start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_R = 8'(8'h40 + k); in_G = 8'h01; in_B = 8'h02;
            tick();
        end
        chk("rst_pre_row", 32'(row), 32'd1);
        chk("rst_pre_col", 32'(col), 32'd0);
        RESET = 1'b1; start = 1'b1;
        tick();
        chk_idle_zero("rst_mid");
        RESET = 1'b0; start = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0; in_valid = 1'b1;
        in_R = 8'h77; in_G = 8'h88; in_B = 8'h99;
        tick();
        chk("rst_new_valid", 32'(out_valid), 32'd1);
        chk("rst_new_row", 32'(row), 32'd0);
        chk("rst_new_col", 32'(col), 32'd0);
        chk("rst_new_pix", pix_out(), 32'(exp_pix(8'h77, 8'h88, 8'h99)));
        in_valid = 1'b0; RESET = 1'b1;
        tick();
        RESET = 1'b0;

        // Mid-frame start pulse and width change are ignored
        width = 4; height = 2; start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_R = 8'(8'h80 + k); in_G = 8'(8'h90 + k); in_B = 8'(8'hA0 + k);
            if (k == 3) begin
                start = 1'b1;
                width = 2;
            end else begin
                start = 1'b0;
            end
            tick();
            chk("f3_row", 32'(row), 32'(k / 4));
            chk("f3_col", 32'(col), 32'(k % 4));
            chk("f3_done", 32'(frame_done), 32'(k == 7));
        end
        in_valid = 1'b0;
        tick();
        chk("f3_after_busy", 32'(busy), 32'd0);

        // Single pixel (100,200,50): grayscale gives 137
        width = 1; height = 1; start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        in_R = 8'd100; in_G = 8'd200; in_B = 8'd50;
        tick();
        in_valid = 1'b0;
        chk("px_valid", 32'(out_valid), 32'd1);
        chk("px_done", 32'(frame_done), 32'd1);
`ifdef PIXEL_RASTER_GRAYSCALE_EN
        chk("px_gray", pix_out(), {8'h00, 8'd137, 8'd137, 8'd137});
`else
        chk("px_raw", pix_out(), {8'h00, 8'd100, 8'd200, 8'd50});
`endif
        tick();
        chk("px_after_busy", 32'(busy), 32'd0);
        chk("px_hold", pix_out(), 32'(exp_pix(8'd100, 8'd200, 8'd50)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
